// File: rtl/sampler_ctrl.sv
// Capture controller for a memory-backed sampler: optional start delay, sampler
// reset, fixed-length fill, then host-paced word readout with a two-cycle gap.
module sampler_ctrl #(
   parameter int FILL_CYCLES = 65536,
   parameter int WORDS       = 4096,
   parameter int DLY_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [DLY_W-1:0]         delay,
   input  logic                     rd_req,
   input  logic [15:0]              samp_dout,
   output logic                     busy,
   output logic                     ready,
   output logic                     rd_valid,
   output logic [15:0]              rd_data,
   output logic                     done,
   output logic [$clog2(WORDS):0]   words_left,
   output logic                     samp_rst,
   output logic                     samp_rd
);

   localparam int FILL_W = $clog2(FILL_CYCLES + 1);
   localparam int WL_W   = $clog2(WORDS) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ARM,
      S_FILL,
      S_READY,
      S_GAP
   } state_t;

   state_t             r_state;
   logic [DLY_W-1:0]   r_dlyCnt;
   logic [FILL_W-1:0]  r_fillCnt;
   logic               r_gapSecond;
   logic               r_busy;
   logic               r_ready;
   logic               r_rdValid;
   logic [15:0]        r_rdData;
   logic               r_done;
   logic [WL_W-1:0]    r_wordsLeft;
   logic               r_sampRst;
   logic               r_sampRd;

   // Outputs are driven from registers that are set on the edge entering the
   // state they describe, so each one reflects the current state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dlyCnt    <= '0;
         r_fillCnt   <= '0;
         r_gapSecond <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
         r_rdValid   <= 1'b0;
         r_rdData    <= 16'h0000;
         r_done      <= 1'b0;
         r_wordsLeft <= '0;
         r_sampRst   <= 1'b0;
         r_sampRd    <= 1'b0;
      end else begin
         r_rdValid <= 1'b0;
         r_sampRd  <= 1'b0;
         r_done    <= 1'b0;
         r_sampRst <= 1'b0;

         if (r_state != S_IDLE && abort) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_wordsLeft <= '0;
            r_dlyCnt    <= '0;
            r_fillCnt   <= '0;
            r_gapSecond <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !abort) begin
                     r_busy <= 1'b1;
                     if (delay != '0) begin
                        r_dlyCnt <= delay;
                        r_state  <= S_WAIT;
                     end else begin
                        r_sampRst <= 1'b1;
                        r_state   <= S_ARM;
                     end
                  end
               end
               S_WAIT: begin
                  if (r_dlyCnt == DLY_W'(1)) begin
                     r_dlyCnt  <= '0;
                     r_sampRst <= 1'b1;
                     r_state   <= S_ARM;
                  end else begin
                     r_dlyCnt <= r_dlyCnt - DLY_W'(1);
                  end
               end
               S_ARM: begin
                  r_fillCnt   <= FILL_W'(FILL_CYCLES);
                  r_wordsLeft <= WL_W'(WORDS);
                  r_state     <= S_FILL;
               end
               S_FILL: begin
                  if (r_fillCnt == FILL_W'(1)) begin
                     r_fillCnt <= '0;
                     r_ready   <= 1'b1;
                     r_state   <= S_READY;
                  end else begin
                     r_fillCnt <= r_fillCnt - FILL_W'(1);
                  end
               end
               S_READY: begin
                  if (rd_req) begin
                     r_rdData    <= samp_dout;
                     r_rdValid   <= 1'b1;
                     r_sampRd    <= 1'b1;
                     r_ready     <= 1'b0;
                     r_gapSecond <= 1'b0;
                     if (r_wordsLeft != '0)
                        r_wordsLeft <= r_wordsLeft - WL_W'(1);
                     r_state     <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (!r_gapSecond) begin
                     r_gapSecond <= 1'b1;
                  end else begin
                     r_gapSecond <= 1'b0;
                     if (r_wordsLeft != '0) begin
                        r_ready <= 1'b1;
                        r_state <= S_READY;
                     end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy       = r_busy;
   assign ready      = r_ready;
   assign rd_valid   = r_rdValid;
   assign rd_data    = r_rdData;
   assign done       = r_done;
   assign words_left = r_wordsLeft;
   assign samp_rst   = r_sampRst;
   assign samp_rd    = r_sampRd;

endmodule
